// File: rtl/scope_capture_if.sv
// Record write bus and ready/ack handshake between scope_capture and the
// display sample RAM / VGA renderer.
interface scope_capture_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned OUT_W  = 8
);
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [2*OUT_W-1:0]    wr_data;
    logic                  frame_ready;
    logic                  frame_ack;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output frame_ready,
        input  frame_ack
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  frame_ready,
        output frame_ack
    );
endinterface

// File: rtl/scope_capture.sv
// Scope sample capture: strobe sync, decimation, 24->OUT_W scaling, level/slope
// trigger with auto timeout, and one-record write into the display sample RAM.
module scope_capture #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             sample_strobe,
    input  logic [23:0]      snd_l,
    input  logic [23:0]      snd_r,
    input  logic             arm,
    input  logic             auto_mode,
    input  logic             trig_src,
    input  logic             trig_slope,
    input  logic [OUT_W-1:0] trig_level,
    input  logic [3:0]       decim,
    output logic [1:0]       state,
    scope_capture_if.master  rec
);
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StReady   = 2'd3
    } state_e;

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_e               state_q, state_d;
    logic [2:0]           sync_q;
    logic                 samp_vld_q;
    logic [OUT_W-1:0]     samp_l_q, samp_r_q;
    logic [3:0]           dec_cnt_q, dec_cnt_d;
    logic [3:0]           decim_q, decim_d;
    logic [TW-1:0]        to_cnt_q, to_cnt_d;
    logic [OUT_W-1:0]     prev_q, prev_d;
    logic                 have_prev_q, have_prev_d;
    logic [ADDR_W-1:0]    wptr_q, wptr_d;
    logic                 wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [2*OUT_W-1:0]   wr_data_q, wr_data_d;
    logic                 frame_ready_q, frame_ready_d;

    logic                 strobe_event;
    logic [OUT_W-1:0]     disp_l, disp_r, cur;
    logic                 active, accept, hit, timed_out, enter_armed;
    logic                 unused_low;

    assign strobe_event = sync_q[1] & ~sync_q[2];

    // Offset-binary display value: top bits of the sample with the sign flipped.
    assign disp_l = {~snd_l[23], snd_l[22 -: OUT_W-1]};
    assign disp_r = {~snd_r[23], snd_r[22 -: OUT_W-1]};
    assign unused_low = ^{snd_l[23-OUT_W:0], snd_r[23-OUT_W:0]};

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            samp_vld_q <= 1'b0;
            samp_l_q   <= '0;
            samp_r_q   <= '0;
        end else begin
            sync_q     <= {sync_q[1:0], sample_strobe};
            samp_vld_q <= strobe_event;
            if (strobe_event) begin
                samp_l_q <= disp_l;
                samp_r_q <= disp_r;
            end
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            dec_cnt_q     <= '0;
            decim_q       <= '0;
            to_cnt_q      <= '0;
            prev_q        <= '0;
            have_prev_q   <= 1'b0;
            wptr_q        <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dec_cnt_q     <= dec_cnt_d;
            decim_q       <= decim_d;
            to_cnt_q      <= to_cnt_d;
            prev_q        <= prev_d;
            have_prev_q   <= have_prev_d;
            wptr_q        <= wptr_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_ready_q <= frame_ready_d;
        end
    end

    assign active    = (state_q == StArmed) || (state_q == StCapture);
    assign accept    = samp_vld_q && active && (dec_cnt_q == decim_q);
    assign cur       = trig_src ? samp_r_q : samp_l_q;
    assign hit       = have_prev_q &&
                       (trig_slope ? ((prev_q > trig_level) && (cur <= trig_level))
                                   : ((prev_q < trig_level) && (cur >= trig_level)));
    // to_cnt_q counts accepted samples before this one.
    assign timed_out = auto_mode && (to_cnt_q >= TW'(TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        dec_cnt_d     = dec_cnt_q;
        decim_d       = decim_q;
        to_cnt_d      = to_cnt_q;
        prev_d        = prev_q;
        have_prev_d   = have_prev_q;
        wptr_d        = wptr_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_ready_d = 1'b0;
        enter_armed   = 1'b0;

        // decim is only re-sampled at a wrap so a mid-record change waits for it.
        if (samp_vld_q && active) begin
            if (dec_cnt_q == decim_q) begin
                dec_cnt_d = '0;
                decim_d   = decim;
            end else begin
                dec_cnt_d = dec_cnt_q + 4'd1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (arm || auto_mode) begin
                    enter_armed = 1'b1;
                end
            end
            StArmed: begin
                if (accept) begin
                    prev_d      = cur;
                    have_prev_d = 1'b1;
                    if (to_cnt_q < TW'(TIMEOUT)) begin
                        to_cnt_d = to_cnt_q + TW'(1);
                    end
                    if (hit || timed_out) begin
                        state_d   = StCapture;
                        wr_en_d   = 1'b1;
                        wr_addr_d = '0;
                        wr_data_d = {samp_l_q, samp_r_q};
                        wptr_d    = ADDR_W'(1);
                    end
                end
            end
            StCapture: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wptr_q;
                    wr_data_d = {samp_l_q, samp_r_q};
                    wptr_d    = wptr_q + ADDR_W'(1);
                    if (&wptr_q) begin
                        state_d = StReady;
                    end
                end
            end
            StReady: begin
                frame_ready_d = ~rec.frame_ack;
                if (rec.frame_ack) begin
                    if (auto_mode) begin
                        enter_armed = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
        endcase

        if (enter_armed) begin
            state_d     = StArmed;
            dec_cnt_d   = '0;
            decim_d     = decim;
            to_cnt_d    = '0;
            prev_d      = '0;
            have_prev_d = 1'b0;
            wptr_d      = '0;
        end
    end

    assign state           = state_q;
    assign rec.wr_en       = wr_en_q;
    assign rec.wr_addr     = wr_addr_q;
    assign rec.wr_data     = wr_data_q;
    assign rec.frame_ready = frame_ready_q;
endmodule

// File: tb/tb_scope_capture.sv
// Scoreboard bench for scope_capture: stimulus queues expected RAM writes,
// a negedge monitor pops and compares each wr_en pulse.
module tb_scope_capture;
    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned OUT_W   = 8;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned DEPTH   = 512;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [2*OUT_W-1:0] data;
    } wr_t;

    logic             sysclk = 1'b0;
    logic             reset;
    logic             sample_strobe;
    logic [23:0]      snd_l, snd_r;
    logic             arm, auto_mode, trig_src, trig_slope;
    logic [OUT_W-1:0] trig_level;
    logic [3:0]       decim;
    logic [1:0]       state;

    scope_capture_if #(.ADDR_W(ADDR_W), .OUT_W(OUT_W)) rec ();

    scope_capture #(.ADDR_W(ADDR_W), .OUT_W(OUT_W), .TIMEOUT(TIMEOUT)) dut (
        .sysclk        (sysclk),
        .reset         (reset),
        .sample_strobe (sample_strobe),
        .snd_l         (snd_l),
        .snd_r         (snd_r),
        .arm           (arm),
        .auto_mode     (auto_mode),
        .trig_src      (trig_src),
        .trig_slope    (trig_slope),
        .trig_level    (trig_level),
        .decim         (decim),
        .state         (state),
        .rec           (rec)
    );

    always #5 sysclk = ~sysclk;

    wr_t exp_q[$];
    wr_t mon_e;
    int  total  = 0;
    int  bad    = 0;
    int  writes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int a, input logic [15:0] d);
        wr_t e;
        e.addr = ADDR_W'(a);
        e.data = d;
        exp_q.push_back(e);
    endtask

    always @(negedge sysclk) begin
        if (rec.wr_en === 1'b1) begin
            writes++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         rec.wr_addr, rec.wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(rec.wr_addr), 32'(mon_e.addr));
                check("wr_data", 32'(rec.wr_data), 32'(mon_e.data));
            end
        end
    end

    // One strobe: 3 cycles high, 5 low; the resulting write lands before return.
    task automatic send(input logic [23:0] l, input logic [23:0] r);
        @(posedge sysclk);
        #1;
        snd_l = l;
        snd_r = r;
        sample_strobe = 1'b1;
        repeat (3) @(posedge sysclk);
        #1 sample_strobe = 1'b0;
        repeat (4) @(posedge sysclk);
    endtask

    // Sample given by display value; junk low bits must be dropped by scaling.
    task automatic dsamp(input logic [7:0] dl, input logic [7:0] dr);
        send({dl ^ 8'h80, 16'h5A3C}, {dr ^ 8'h80, 16'hC3A5});
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (rec.frame_ready !== 1'b1 && n < 50) begin
            @(posedge sysclk);
            #1;
            n++;
        end
        check({name, "_frame_ready"}, 32'(rec.frame_ready), 32'd1);
        check({name, "_state_ready"}, 32'(state), 32'd3);
        check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic ack(input logic am, input string name);
        auto_mode = am;
        @(posedge sysclk);
        #1 rec.frame_ack = 1'b1;
        @(posedge sysclk);
        #1 rec.frame_ack = 1'b0;
        check({name, "_frame_ready_low"}, 32'(rec.frame_ready), 32'd0);
        check({name, "_state_after_ack"}, 32'(state), am ? 32'd1 : 32'd0);
    endtask

    task automatic arm_pulse(input string name);
        @(posedge sysclk);
        #1 arm = 1'b1;
        @(posedge sysclk);
        #1 arm = 1'b0;
        check({name, "_armed"}, 32'(state), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1);
    end

    initial begin
        int w0;
        logic [7:0] j;
        reset = 1'b1;
        sample_strobe = 1'b0;
        snd_l = '0;
        snd_r = '0;
        arm = 1'b0;
        auto_mode = 1'b0;
        trig_src = 1'b0;
        trig_slope = 1'b0;
        trig_level = 8'h80;
        decim = 4'd0;
        rec.frame_ack = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        check("rst_wr_en", 32'(rec.wr_en), 32'd0);
        check("rst_wr_addr", 32'(rec.wr_addr), 32'd0);
        check("rst_wr_data", 32'(rec.wr_data), 32'd0);
        check("rst_frame_ready", 32'(rec.frame_ready), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        reset = 1'b0;
        @(posedge sysclk);
        #1 check("idle_after_reset", 32'(state), 32'd0);

        // Ramp from -0x800000 by 0x010000: display value i, trigger at i=128 (0x80).
        arm_pulse("ramp");
        for (int k = 0; k < int'(DEPTH); k++) push_exp(k, {8'((128 + k) & 255), 8'hFF});
        for (int i = 0; i < 640; i++) send(24'h800000 + (24'(i) << 16), 24'h7FFFFF);
        wait_ready("ramp");

        // Samples while READY and after a manual-mode ack must not be written.
        w0 = writes;
        dsamp(8'h10, 8'h20);
        ack(1'b0, "ack_manual");
        dsamp(8'h00, 8'h00);
        dsamp(8'hFF, 8'hFF);
        dsamp(8'h00, 8'h00);
        check("no_write_idle", 32'(writes - w0), 32'd0);
        check("still_idle", 32'(state), 32'd0);

        // Auto mode, flat zero input: forced trigger on the 16th accepted sample.
        for (int k = 0; k < int'(DEPTH); k++) push_exp(k, 16'h8080);
        auto_mode = 1'b1;
        @(posedge sysclk);
        #1 check("auto_armed", 32'(state), 32'd1);
        for (int i = 0; i < int'(TIMEOUT) + int'(DEPTH) - 1; i++) send(24'h000000, 24'h000000);
        wait_ready("timeout");
        decim = 4'd3;
        trig_level = 8'h40;
        ack(1'b1, "ack_auto");
        auto_mode = 1'b0;

        // decim=3: accepted indices 3,7,...; rising through 0x40 at index 67.
        for (int k = 0; k < int'(DEPTH); k++) begin
            j = 8'((67 + 4 * k) & 255);
            push_exp(k, {j, j});
        end
        for (int i = 0; i < 67 + 4 * int'(DEPTH); i++) begin
            j = 8'(i & 255);
            dsamp(j, j);
        end
        wait_ready("decim");
        decim = 4'd0;
        ack(1'b0, "ack_decim");

        // Falling on right: left crossing is ignored, right 0xA0->0x80 triggers.
        trig_src = 1'b1;
        trig_slope = 1'b1;
        trig_level = 8'h80;
        arm_pulse("fall");
        push_exp(0, 16'h9080);
        for (int k = 1; k < int'(DEPTH); k++) push_exp(k, {8'(k), ~8'(k)});
        dsamp(8'h90, 8'hC0);
        dsamp(8'h70, 8'hB0);
        dsamp(8'h90, 8'hA0);
        check("fall_no_early_trig", 32'(exp_q.size()), DEPTH);
        dsamp(8'h90, 8'h80);
        for (int k = 1; k < int'(DEPTH); k++) dsamp(8'(k), ~8'(k));
        wait_ready("fall");
        ack(1'b0, "ack_fall");

        // Reset during CAPTURE right after the write at address 100.
        trig_src = 1'b0;
        trig_slope = 1'b0;
        arm_pulse("abort");
        for (int k = 0; k <= 100; k++) push_exp(k, {8'(8'h80 + k), 8'h11});
        dsamp(8'h7E, 8'h11);
        dsamp(8'h7F, 8'h11);
        for (int k = 0; k <= 100; k++) dsamp(8'(8'h80 + k), 8'h11);
        check("abort_reached_100", 32'(exp_q.size()), 32'd0);
        check("abort_in_capture", 32'(state), 32'd2);
        #3 reset = 1'b1;
        #1;
        check("abort_wr_en", 32'(rec.wr_en), 32'd0);
        check("abort_wr_addr", 32'(rec.wr_addr), 32'd0);
        check("abort_wr_data", 32'(rec.wr_data), 32'd0);
        check("abort_frame_ready", 32'(rec.frame_ready), 32'd0);
        check("abort_state", 32'(state), 32'd0);
        w0 = writes;
        dsamp(8'h90, 8'h11);
        check("abort_no_write", 32'(writes - w0), 32'd0);
        @(posedge sysclk);
        #1 reset = 1'b0;
        @(posedge sysclk);
        #1 check("abort_idle_after", 32'(state), 32'd0);

        arm_pulse("restart");
        push_exp(0, 16'h8011);
        push_exp(1, 16'h8111);
        push_exp(2, 16'h8211);
        dsamp(8'h7E, 8'h11);
        dsamp(8'h7F, 8'h11);
        dsamp(8'h80, 8'h11);
        dsamp(8'h81, 8'h11);
        dsamp(8'h82, 8'h11);
        check("restart_drained", 32'(exp_q.size()), 32'd0);
        check("restart_capture", 32'(state), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scope_capture.md
# scope_capture

Sample-capture and trigger stage placed directly downstream of the I2S receiver in the VGA scope. It takes the 24-bit left/right capture words and the per-frame sample strobe, decimates and scales them to 8-bit display values, and waits for a level/slope trigger. It then writes one screen-width record of samples into the display sample RAM and hands that record to the VGA renderer with a ready/ack handshake.

## Interface
- ADDR_W, 9: record length is 2^ADDR_W samples (512).
- OUT_W, 8: display sample width per channel.
- TIMEOUT, 4096: number of accepted samples in auto mode before a forced trigger.
- sysclk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- sample_strobe  in  1  from I2S sampleclk; sampled in the sysclk domain; snd_l/snd_r are stable while it is high.
- snd_l  in  24  left sample, two's complement.
- snd_r  in  24  right sample, two's complement.
- arm  in  1  single-shot arm request, level-sensed in IDLE.
- auto_mode  in  1  1 = free-running with timeout re-arm.
- trig_src  in  1  0 = left channel, 1 = right channel.
- trig_slope  in  1  0 = rising, 1 = falling.
- trig_level  in  OUT_W  trigger threshold in display (offset-binary) units.
- decim  in  4  keep 1 of every decim+1 samples.
- wr_en  out  1  RAM write strobe, one cycle per sample.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  2*OUT_W  {left, right} display values.
- frame_ready  out  1  complete record in RAM.
- frame_ack  in  1  renderer has consumed the record.
- state  out  2  current FSM state, for the status LEDs.

## Operation
- Strobe path: 2-FF synchronizer plus a third register. The rising-edge event is sync2 & ~sync3.
- On each event, snd_l and snd_r are latched.
- Scaling: disp = {~s[23], s[22:24-OUT_W]}, which is offset binary. Zero maps to 0x80, full-scale negative to 0x00, full-scale positive to 0xFF.
- Decimation counter:
  - Active in ARMED and CAPTURE; cleared to 0 on entry to ARMED.
  - A sample is "accepted" when the counter equals decim; the counter then wraps to 0.
  - decim = 0 accepts every sample.
  - A change of decim mid-record takes effect at the next wrap.
- States (state encoding): IDLE=0, ARMED=1, CAPTURE=2, READY=3.
- IDLE:
  - wr_en = 0.
  - arm = 1 or auto_mode = 1 → ARMED.
- ARMED:
  - Compares consecutive accepted samples of the selected channel: prev and cur.
  - Rising trigger: prev < trig_level && cur >= trig_level. Falling trigger: prev > trig_level && cur <= trig_level.
  - The first accepted sample after entry only loads prev and cannot trigger.
  - Auto timeout counter counts accepted samples. If auto_mode = 1 and it reaches TIMEOUT, a forced trigger occurs on that sample.
  - On a trigger, the triggering sample is written at address 0 and the FSM moves to CAPTURE.
- CAPTURE:
  - Each accepted sample produces one write with wr_addr incremented by 1.
  - After the write at address 2^ADDR_W−1 → READY. There is no wrap; exactly 2^ADDR_W writes per record.
- READY:
  - frame_ready = 1; incoming samples are ignored.
  - On frame_ack = 1: frame_ready → 0, then → ARMED if auto_mode = 1, else → IDLE.
- frame_ack outside READY is ignored. arm outside IDLE is ignored.
- A trigger and the timeout on the same sample is a single trigger event.
- trig_src, trig_slope and trig_level are sampled every accepted sample. Changing them mid-record does not affect CAPTURE.

## Timing
- Reset values:
  - wr_en = 0, wr_addr = 0, wr_data = 0, frame_ready = 0, state = IDLE.
  - Synchronizers, counters and prev are all 0.
- Reset is asynchronous. Asserting it mid-CAPTURE aborts the record immediately; no further writes occur.
- Latency: strobe first seen high at sysclk edge k → data latched at k+2 → wr_en/wr_addr/wr_data registered high at k+3, for exactly one cycle.
- The minimum strobe high time is 3 sysclk cycles. A strobe held high produces one event only.
- frame_ready is registered. It rises the cycle after the final write and falls the cycle after frame_ack is seen high.
- The ARMED state is visible one cycle after the frame_ack cycle.

## Test plan
- Reset, then auto_mode = 0, arm pulse, ramp on left from −0x800000 upward in steps of 0x010000 per strobe, trig_level = 0x80, rising:
  - Trigger occurs on the first sample ≥ 0x000000; wr_data[15:8] = 0x80 at wr_addr = 0.
  - 512 consecutive writes follow, then frame_ready = 1.
- In READY, pulse frame_ack with auto_mode = 0 → frame_ready = 0 the next cycle, state = IDLE, and no writes until the next arm.
- auto_mode = 1 with a constant input of 0x000000 (no crossing), TIMEOUT = 16:
  - A forced trigger occurs on the 16th accepted sample.
  - A full record follows with all wr_data = 0x8080.
- decim = 3, with strobes carrying an incrementing index:
  - Only every 4th sample is written.
  - wr_addr is contiguous while the source values step by 4.
- Falling slope on the right channel, trig_src = 1, left channel crossing the level and right channel not → no trigger. Then the right channel crosses downward → trigger, with the triggering sample at wr_addr = 0.
- Assert reset at wr_addr = 100 during CAPTURE:
  - All outputs are 0 asynchronously.
  - After release, state = IDLE and the next record starts at wr_addr = 0.
